button_pulse: RTL and testbench

- Conditions the two raw "inc"/"dec" push-buttons on the board into clean single-cycle pulses.
- Feeds the inc/dec pulse inputs of the field-select and time-set counters directly.
- Each channel has a 2-flop synchroniser, a debounce filter, press-edge detection and an optional auto-repeat timer.
- Mutual exclusion guarantees downstream counters never see inc and dec in the same cycle.

---
 rtl/button_pulse.sv | 179 +++++++++++++++++
 tb/tb_button_pulse.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : button_pulse
// Brief    : Conditions the raw inc/dec push-buttons into clean one-cycle
//            pulses: 2-flop synchroniser, debounce filter, press-edge pulse,
//            optional auto-repeat, and inc/dec mutual exclusion.
// Macro    : BUTTON_PULSE_AUTO_REPEAT_EN - when defined, builds the per-channel
//            auto-repeat FSM and timer; otherwise one pulse per accepted press.
// Revision : 1.0 - initial release
// ============================================================================
module button_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 26,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn_inc,
  input  logic i_btn_dec,
  output logic o_inc_pulse,
  output logic o_dec_pulse,
  output logic o_inc_held,
  output logic o_dec_held
);

  // Raw pin level of a released button.
  localparam logic             c_released_raw = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] c_deb_last     = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam logic [63:0]      c_cnt_lim      = 64'd1 << CNT_W;

  // Reject parameter sets whose compare values cannot be reached by the counters.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      64'(DEBOUNCE_CYCLES) >= c_cnt_lim || 64'(REPEAT_DELAY) >= c_cnt_lim ||
      64'(REPEAT_PERIOD) >= c_cnt_lim) begin : g_bad_params
    $error("button_pulse: cycle parameters must be >= 1 and < 2**CNT_W");
  end

`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] c_dly_last = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_per_last = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } rpt_state_t;
`endif

  // Channel 0 = inc, channel 1 = dec.
  logic [1:0] w_btn_raw;
  logic [1:0] w_acc_nxt;   // accepted level after the coming edge
  logic [1:0] w_rise;      // accepted level goes 0->1 on the coming edge
  logic [1:0] w_held;
  logic [1:0] w_pulse;
  logic       w_both_nxt;  // both buttons accepted after the coming edge

  assign w_btn_raw  = {i_btn_dec, i_btn_inc};
  // Looking at the next accepted levels means a pulse register can never be
  // high during a cycle in which both held outputs are high.
  assign w_both_nxt = &w_acc_nxt;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             r_sync1;
    logic             r_sync2;
    logic             r_acc;
    logic             r_pulse;
    logic [CNT_W-1:0] r_deb_cnt;
    logic             w_level;
    logic             w_differ;
    logic             w_accept;

    // Two-flop synchroniser; the raw pin is sampled nowhere else. The flops
    // hold the raw level, so a reset value of "released" is the pin's idle level.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_sync1 <= c_released_raw;
        r_sync2 <= c_released_raw;
      end else begin
        r_sync1 <= w_btn_raw[g];
        r_sync2 <= r_sync1;
      end
    end

    // Normalised level: 1 = pressed, regardless of board polarity.
    assign w_level      = r_sync2 ^ c_released_raw;
    assign w_differ     = w_level ^ r_acc;
    assign w_accept     = w_differ & (r_deb_cnt == c_deb_last);
    assign w_acc_nxt[g] = r_acc ^ w_accept;
    assign w_rise[g]    = w_accept & ~r_acc;
    assign w_held[g]    = r_acc;
    assign w_pulse[g]   = r_pulse;

    // Debounce: count consecutive disagreeing cycles, toggle on the last one.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_acc     <= 1'b0;
        r_deb_cnt <= '0;
      end else begin
        r_acc <= w_acc_nxt[g];
        if (w_differ && !w_accept) begin
          r_deb_cnt <= r_deb_cnt + c_cnt_one;
        end else begin
          r_deb_cnt <= '0;
        end
      end
    end

`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
    rpt_state_t       r_state;
    logic [CNT_W-1:0] r_rpt_cnt;

    // Press pulse plus auto-repeat; release or a two-button hold parks in IDLE.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_state   <= S_IDLE;
        r_rpt_cnt <= '0;
        r_pulse   <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (!w_acc_nxt[g] || w_both_nxt) begin
          r_state   <= S_IDLE;
          r_rpt_cnt <= '0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_rise[g]) begin
                r_pulse   <= 1'b1;
                r_state   <= S_DELAY;
                r_rpt_cnt <= '0;
              end
            end
            S_DELAY: begin
              if (r_rpt_cnt == c_dly_last) begin
                r_pulse   <= 1'b1;
                r_state   <= S_REPEAT;
                r_rpt_cnt <= '0;
              end else begin
                r_rpt_cnt <= r_rpt_cnt + c_cnt_one;
              end
            end
            S_REPEAT: begin
              if (r_rpt_cnt == c_per_last) begin
                r_pulse   <= 1'b1;
                r_rpt_cnt <= '0;
              end else begin
                r_rpt_cnt <= r_rpt_cnt + c_cnt_one;
              end
            end
            default: begin
              r_state   <= S_IDLE;
              r_rpt_cnt <= '0;
            end
          endcase
        end
      end
    end
`else
    // One pulse per accepted press, suppressed when the other button is held.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_pulse <= 1'b0;
      end else begin
        r_pulse <= w_rise[g] & ~w_both_nxt;
      end
    end
`endif
  end

  assign o_inc_pulse = w_pulse[0];
  assign o_dec_pulse = w_pulse[1];
  assign o_inc_held  = w_held[0];
  assign o_dec_held  = w_held[1];

endmodule
`default_nettype wire

// File: tb/tb_button_pulse.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_button_pulse
// Brief    : Self-checking bench for button_pulse with a cycle-level reference
//            model; follows BUTTON_PULSE_AUTO_REPEAT_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_pulse;

  localparam int DEB = 4;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int CW  = 26;
`ifdef BUTTON_PULSE_AUTO_REPEAT_EN
  localparam bit AUTO_RPT = 1'b1;
`else
  localparam bit AUTO_RPT = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset_n;
  logic i_btn_inc;
  logic i_btn_dec;
  logic o_inc_pulse;
  logic o_dec_pulse;
  logic o_inc_held;
  logic o_dec_held;
  logic [3:0] w_obs;

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;

  // Reference model state ([0] = inc, [1] = dec, 1 = pressed)
  logic [1:0] m_dly1;
  logic [1:0] m_dly2;
  logic [1:0] m_acc;
  logic [1:0] m_pulse;
  logic [1:0] m_armed;
  int         m_run    [2];
  int         m_tpress [2];

  button_pulse #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .CNT_W          (CW),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_btn_inc  (i_btn_inc),
    .i_btn_dec  (i_btn_dec),
    .o_inc_pulse(o_inc_pulse),
    .o_dec_pulse(o_dec_pulse),
    .o_inc_held (o_inc_held),
    .o_dec_held (o_dec_held)
  );

  assign w_obs = {o_dec_held, o_inc_held, o_dec_pulse, o_inc_pulse};

  always #5 i_clk = ~i_clk;

  task automatic model_reset();
    m_dly1  = 2'b00;
    m_dly2  = 2'b00;
    m_acc   = 2'b00;
    m_pulse = 2'b00;
    m_armed = 2'b00;
    for (int c = 0; c < 2; c++) begin
      m_run[c]    = 0;
      m_tpress[c] = 0;
    end
  endtask

  // One clock edge: the level seen is the pin two edges ago; a level is
  // accepted once it has differed for DEB consecutive edges; pulses fire on
  // press and then at DLY, DLY+PER, ... edges after the press while held alone.
  task automatic model_edge();
    logic [1:0] lvl;
    logic [1:0] acc_new;
    logic [1:0] rise;
    logic       both;
    int         d;
    edge_n++;
    lvl     = m_dly2;
    m_dly2  = m_dly1;
    m_dly1  = {~i_btn_dec, ~i_btn_inc};
    acc_new = m_acc;
    for (int c = 0; c < 2; c++) begin
      if (lvl[c] != m_acc[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          acc_new[c] = lvl[c];
          m_run[c]   = 0;
        end
      end else begin
        m_run[c] = 0;
      end
    end
    rise  = acc_new & ~m_acc;
    both  = &acc_new;
    m_acc = acc_new;
    for (int c = 0; c < 2; c++) begin
      m_pulse[c] = 1'b0;
      d = edge_n - m_tpress[c];
      if (!acc_new[c] || both) begin
        m_armed[c] = 1'b0;
      end else if (rise[c]) begin
        m_pulse[c]  = 1'b1;
        m_armed[c]  = 1'b1;
        m_tpress[c] = edge_n;
      end else if (m_armed[c] && AUTO_RPT && d >= DLY && ((d - DLY) % PER) == 0) begin
        m_pulse[c] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (!i_reset_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_btn_inc = 1'b1;
    i_btn_dec = 1'b1;
    model_reset();
    #2;
    n_vec++;
    if (w_obs !== 4'b0000) begin
      n_err++; $display("FAIL reset_async: outputs got %b expected 0000", w_obs);
    end
    repeat (3) begin
      tick();
      n_vec++;
      if (w_obs !== 4'b0000) begin
        n_err++; $display("FAIL reset_hold: outputs got %b expected 0000", w_obs);
      end
    end
    i_reset_n = 1'b1;
    repeat (10) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL reset_idle: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
    end
  endtask

  task automatic test_single_press();
    int first = 0;
    int hold;
    hold = $urandom_range(12, 5);
    i_btn_inc = 1'b0;
    for (int k = 1; k <= 6 + hold + 12; k++) begin
      tick();
      if (k == 6 + hold) i_btn_inc = 1'b1;
      n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL single_press: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse && first == 0) first = k;
    end
    n_vec++;
    if (first != DEB + 2) begin
      n_err++; $display("FAIL press_latency: first pulse at edge %0d expected %0d", first, DEB + 2);
    end
  endtask

  task automatic test_glitch();
    int npulse = 0;
    int len;
    for (int gi = 0; gi < 5; gi++) begin
      len = $urandom_range(DEB - 1, 1);
      i_btn_dec = 1'b0;
      for (int k = 0; k < len; k++) begin
        tick(); n_vec++;
        if (w_obs !== {m_acc, m_pulse}) begin
          n_err++; $display("FAIL glitch_low: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
        end
        if (o_dec_pulse) npulse++;
      end
      i_btn_dec = 1'b1;
      len = $urandom_range(4, 1);
      for (int k = 0; k < len + 8; k++) begin
        tick(); n_vec++;
        if (w_obs !== {m_acc, m_pulse}) begin
          n_err++; $display("FAIL glitch_high: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
        end
        if (o_dec_pulse) npulse++;
      end
    end
    n_vec++;
    if (npulse != 0) begin
      n_err++; $display("FAIL glitch_rejected: dec pulses got %0d expected 0", npulse);
    end
    len = $urandom_range(15, DEB + 4);
    i_btn_dec = 1'b0;
    for (int k = 1; k <= len + 12; k++) begin
      tick();
      if (k == len) i_btn_dec = 1'b1;
      n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL dec_press: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_dec_pulse) npulse++;
    end
    n_vec++;
    if (npulse != 1) begin
      n_err++; $display("FAIL dec_single: dec pulses got %0d expected 1", npulse);
    end
  endtask

  task automatic test_auto_repeat();
    int first = 0;
    int nrep = 0;
    int fall = 0;
    int nafter = 0;
    i_btn_inc = 1'b0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL rpt_press: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse) first = k;
    end
    n_vec++;
    if (first != DEB + 2) begin
      n_err++; $display("FAIL rpt_first: first pulse at edge %0d expected %0d", first, DEB + 2);
    end
    for (int d = 1; d <= 60; d++) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL rpt_hold: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse && d < 60) nrep++;
    end
    n_vec++;
    if (nrep != (AUTO_RPT ? 8 : 0)) begin
      n_err++; $display("FAIL rpt_count: repeats got %0d expected %0d", nrep, AUTO_RPT ? 8 : 0);
    end
    i_btn_inc = 1'b1;
    for (int k = 1; k <= 20 && fall == 0; k++) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL rpt_release: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (!o_inc_held) fall = k;
    end
    n_vec++;
    if (fall != DEB + 2) begin
      n_err++; $display("FAIL release_latency: held fell at edge %0d expected %0d", fall, DEB + 2);
    end
    repeat (15) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL rpt_after: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse) nafter++;
    end
    n_vec++;
    if (nafter != 0) begin
      n_err++; $display("FAIL rpt_stopped: pulses after release got %0d expected 0", nafter);
    end
  endtask

  task automatic test_mutex();
    int first = 0;
    int cnt = 0;
    i_btn_inc = 1'b0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL mutex_inc: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse) first = k;
    end
    for (int k = 0; k < 10 + 40 + 30 + 12; k++) begin
      if (k == 10) i_btn_dec = 1'b0;
      if (k == 50) i_btn_dec = 1'b1;
      if (k == 80) i_btn_inc = 1'b1;
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL mutex_both: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (k >= 10 && (o_inc_pulse || o_dec_pulse)) cnt++;
    end
    n_vec++;
    if (cnt != 0) begin
      n_err++; $display("FAIL mutex_pulses: pulses got %0d expected 0", cnt);
    end
    first = 0;
    i_btn_inc = 1'b0;
    for (int k = 1; k <= 20 && first == 0; k++) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL mutex_rearm: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse) first = k;
    end
    n_vec++;
    if (first != DEB + 2) begin
      n_err++; $display("FAIL mutex_repress: pulse at edge %0d expected %0d", first, DEB + 2);
    end
    i_btn_inc = 1'b1;
    repeat (12) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL mutex_idle: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int first = 0;
    int npulse = 0;
    i_btn_inc = 1'b0;
    repeat (DEB + 2 + 30) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL midrst_pre: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
    end
    #2;
    i_reset_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (w_obs !== 4'b0000) begin
      n_err++; $display("FAIL midrst_async: outputs got %b expected 0000", w_obs);
    end
    repeat (2) begin
      tick(); n_vec++;
      if (w_obs !== 4'b0000) begin
        n_err++; $display("FAIL midrst_hold: outputs got %b expected 0000", w_obs);
      end
    end
    i_reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL midrst_post: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      if (o_inc_pulse) begin
        npulse++;
        if (first == 0) first = k;
      end
    end
    n_vec++;
    if (first != DEB + 2) begin
      n_err++; $display("FAIL midrst_latency: pulse at edge %0d expected %0d", first, DEB + 2);
    end
    n_vec++;
    if (npulse != (AUTO_RPT ? 4 : 1)) begin
      n_err++; $display("FAIL midrst_count: pulses got %0d expected %0d", npulse, AUTO_RPT ? 4 : 1);
    end
    i_btn_inc = 1'b1;
    repeat (12) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL midrst_idle: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
    end
  endtask

  task automatic test_random_mix();
    int left_i;
    int left_d;
    left_i = $urandom_range(30, 1);
    left_d = $urandom_range(30, 1);
    for (int k = 0; k < 800; k++) begin
      if (left_i == 0) begin
        i_btn_inc = ~i_btn_inc;
        left_i = $urandom_range(45, 1);
      end else begin
        left_i--;
      end
      if (left_d == 0) begin
        i_btn_dec = ~i_btn_dec;
        left_d = $urandom_range(45, 1);
      end else begin
        left_d--;
      end
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL random_mix: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
      n_vec++;
      if ((o_inc_pulse & o_dec_pulse) !== 1'b0) begin
        n_err++; $display("FAIL exclusion: inc&dec pulse got %b expected 0 edge %0d", o_inc_pulse & o_dec_pulse, edge_n);
      end
    end
    i_btn_inc = 1'b1;
    i_btn_dec = 1'b1;
    repeat (12) begin
      tick(); n_vec++;
      if (w_obs !== {m_acc, m_pulse}) begin
        n_err++; $display("FAIL random_idle: {dh,ih,dp,ip} got %b expected %b edge %0d", w_obs, {m_acc, m_pulse}, edge_n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_auto_repeat();
    test_mutex();
    test_reset_mid_press();
    test_random_mix();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d miscompares %0d", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
